// File: rtl/tdm_demux_4ch_if.sv
// tdm_demux_4ch_if: bus between the TDM word source and the 4-channel demux.
// The master drives the TDM stream; the slave (the demux) drives the
// recovered channel registers and the framing status.
interface tdm_demux_4ch_if #(
  parameter int WIDTH = 4
);
  // TDM stream, driven by the master
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             fsync;

  // Recovered channels and framing status, driven by the demux
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] d4;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;
  logic [7:0]       err_cnt;

  modport master (
    output din, din_valid, fsync,
    input  d1, d2, d3, d4, frame_valid, locked, slot, sync_err, err_cnt
  );

  modport slave (
    input  din, din_valid, fsync,
    output d1, d2, d3, d4, frame_valid, locked, slot, sync_err, err_cnt
  );
endinterface

// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: 4-channel TDM receiver.
// Locks onto the frame-sync marker, gathers slots 0..2 in shadow registers
// and commits all four channels together when the slot-3 word arrives, so
// d1..d4 only ever show complete frames. Framing errors pulse sync_err.
// Optional feature: define TDM_ERRCNT_EN to build the saturating framing
// error counter on err_cnt; otherwise err_cnt is tied to zero.
module tdm_demux_4ch #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_4ch_if.slave    bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_shadow0;
  logic [WIDTH-1:0] r_shadow1;
  logic [WIDTH-1:0] r_shadow2;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [WIDTH-1:0] r_d3;
  logic [WIDTH-1:0] r_d4;
  logic             r_frame_valid;
  logic             r_sync_err;

  state_t           w_state_nxt;
  logic [1:0]       w_slot_nxt;
  logic             w_wr0;
  logic             w_wr1;
  logic             w_wr2;
  logic             w_commit;
  logic             w_err;

  // Next-state decode: classify each valid word against the framing rules
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_wr0       = 1'b0;
    w_wr1       = 1'b0;
    w_wr2       = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;

    if (bus.din_valid) begin
      case (r_state)
        HUNT: begin
          // Anything but a sync word is noise while hunting
          if (bus.fsync) begin
            w_wr0       = 1'b1;
            w_slot_nxt  = 2'd1;
            w_state_nxt = LOCKED;
          end
        end

        LOCKED: begin
          if (bus.fsync) begin
            // Sync always restarts the frame; mid-frame it is an early sync
            // and the partial frame is abandoned
            w_wr0      = 1'b1;
            w_slot_nxt = 2'd1;
            w_err      = (r_slot != 2'd0);
          end else begin
            case (r_slot)
              2'd0: begin
                // Sync missing where a frame must start: lost lock
                w_err       = 1'b1;
                w_slot_nxt  = 2'd0;
                w_state_nxt = HUNT;
              end
              2'd1: begin
                w_wr1      = 1'b1;
                w_slot_nxt = 2'd2;
              end
              2'd2: begin
                w_wr2      = 1'b1;
                w_slot_nxt = 2'd3;
              end
              default: begin
                w_commit   = 1'b1;
                w_slot_nxt = 2'd0;
              end
            endcase
          end
        end

        default: begin
          w_state_nxt = HUNT;
          w_slot_nxt  = 2'd0;
        end
      endcase
    end
  end

  // State and slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= HUNT;
      r_slot  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Shadow registers collecting slots 0..2 of the frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shadow bank is only three words, so it is reset like any
    // other register rather than left uninitialised as a RAM would be.
    if (!rst_n) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else begin
      if (w_wr0) r_shadow0 <= bus.din;
      if (w_wr1) r_shadow1 <= bus.din;
      if (w_wr2) r_shadow2 <= bus.din;
    end
  end

  // Channel outputs: all four updated together on the slot-3 word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_d4 <= '0;
    end else if (w_commit) begin
      r_d1 <= r_shadow0;
      r_d2 <= r_shadow1;
      r_d3 <= r_shadow2;
      r_d4 <= bus.din;
    end
  end

  // One-cycle status pulses for frame completion and framing errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      r_sync_err    <= w_err;
    end
  end

`ifdef TDM_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating framing error counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = 8'd0;
`endif

  assign bus.d1          = r_d1;
  assign bus.d2          = r_d2;
  assign bus.d3          = r_d3;
  assign bus.d4          = r_d4;
  assign bus.frame_valid = r_frame_valid;
  assign bus.sync_err    = r_sync_err;
  assign bus.locked      = (r_state == LOCKED);
  assign bus.slot        = r_slot;

endmodule
